// File: rtl/oled_pkg.sv
// Shared constants for the 128x64 page-organised OLED framebuffer and its display driver.
// Byte address = {page, column}; bit b of a byte is row page*8+b (LSB at the top).
package oled_pkg;

    localparam int DISPLAY_WIDTH  = 128;
    localparam int DISPLAY_HEIGHT = 64;
    localparam int PAGES          = DISPLAY_HEIGHT / 8;
    localparam int ADDR_W         = $clog2(DISPLAY_WIDTH) + $clog2(PAGES);

    localparam logic RMODE_HORZ = 1'b0;
    localparam logic RMODE_COL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WR_RD,
        ST_WR_WB,
        ST_RD_COL,
        ST_RD_HORZ
    } fb_state_e;

    function automatic logic [7:0] put_bit(input logic [7:0] b, input logic [2:0] idx,
                                           input logic v);
        logic [7:0] r;
        r      = b;
        r[idx] = v;
        return r;
    endfunction

endpackage

// File: rtl/fb_bram.sv
// Single-port synchronous RAM, read-before-write, one-cycle read latency.
// Shaped for block-RAM inference: no reset on the array or the read register.
module fb_bram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/oled_framebuffer.sv
// 1bpp page-organised framebuffer: pixel RMW (2 cycles), clear sweep, column/horizontal byte reads.
// ready is high only in IDLE; requests seen while busy are dropped and must be re-asserted.
module oled_framebuffer
    import oled_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = oled_pkg::DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = oled_pkg::DISPLAY_HEIGHT,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       ready,
    input  logic       clear,
    input  logic       we,
    input  logic [7:0] w_xpos,
    input  logic [7:0] w_ypos,
    input  logic       w_pixel,
    input  logic       re,
    input  logic [7:0] r_xpos,
    input  logic [7:0] r_ypos,
    input  logic       r_mode,
    output logic [7:0] dout,
    output logic       r_valid
);

    localparam int X_W      = $clog2(DISPLAY_WIDTH);
    localparam int PAGE_CNT = DISPLAY_HEIGHT / 8;
    localparam int PG_W     = $clog2(PAGE_CNT);
    localparam int AW       = X_W + PG_W;

    localparam logic [8:0]    X_LIM      = 9'(DISPLAY_WIDTH);
    localparam logic [8:0]    Y_LIM      = 9'(DISPLAY_HEIGHT);
    localparam logic [5:0]    PG_LIM     = 6'(PAGE_CNT);
    localparam logic [AW-1:0] CNT_MAX    = {AW{1'b1}};
    localparam logic [AW-1:0] COL_LAST   = AW'(2);
    localparam logic [AW-1:0] HORZ_LAST  = AW'(8);
    localparam fb_state_e     RST_STATE  = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    fb_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [7:0]    x_q, x_d, y_q, y_d;
    logic [7:0]    acc_q, acc_d;
    logic [7:0]    dout_q, dout_d;
    logic          pix_q, pix_d;
    logic          r_valid_q, r_valid_d;

    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata, ram_rdata;

    logic          x_ok, y_ok, nxt_ok, hx_ok, hxp_ok, h_bit;
    logic [5:0]    page_nxt;
    logic [8:0]    hx, hxp;
    logic [AW-1:0] req_addr, base_addr, nxt_addr, h_addr;
    logic [15:0]   col_word;

    assign x_ok     = ({1'b0, x_q} < X_LIM);
    assign y_ok     = ({1'b0, y_q} < Y_LIM);
    assign page_nxt = {1'b0, y_q[7:3]} + 6'd1;
    assign nxt_ok   = (page_nxt < PG_LIM);

    // hx walks the column being fetched; hxp is the column whose byte is arriving now.
    assign hx       = {1'b0, x_q} + {5'd0, cnt_q[3:0]};
    assign hxp      = hx - 9'd1;
    assign hx_ok    = (hx < X_LIM);
    assign hxp_ok   = (hxp < X_LIM);
    assign h_bit    = hxp_ok && y_ok && ram_rdata[y_q[2:0]];

    assign req_addr  = {r_ypos[PG_W+2:3], r_xpos[X_W-1:0]};
    assign base_addr = {y_q[PG_W+2:3], x_q[X_W-1:0]};
    assign nxt_addr  = {page_nxt[PG_W-1:0], x_q[X_W-1:0]};
    assign h_addr    = {y_q[PG_W+2:3], hx[X_W-1:0]};

    // Page p in the low byte, page p+1 (or zeros past the last page) in the high byte.
    assign col_word = (y_q[2:0] == 3'd0) ? {8'h00, ram_rdata}
                                         : {(nxt_ok ? ram_rdata : 8'h00), acc_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        pix_d     = pix_q;
        acc_d     = acc_q;
        dout_d    = dout_q;
        r_valid_d = 1'b0;
        ram_en    = 1'b1;
        ram_we    = 1'b0;
        ram_addr  = base_addr;
        ram_wdata = 8'h00;

        case (state_q)
            ST_IDLE: begin
                // Speculative fetch so an aligned column read completes one cycle after acceptance.
                ram_addr = req_addr;
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (we) begin
                    state_d = ST_WR_RD;
                    x_d     = w_xpos;
                    y_d     = w_ypos;
                    pix_d   = w_pixel;
                end else if (re) begin
                    x_d   = r_xpos;
                    y_d   = r_ypos;
                    acc_d = 8'h00;
                    cnt_d = '0;
                    if (r_mode == RMODE_COL) begin
                        state_d = ST_RD_COL;
                        if (r_ypos[2:0] == 3'd0) begin
                            cnt_d = COL_LAST;
                        end
                    end else begin
                        state_d = ST_RD_HORZ;
                    end
                end
            end
            ST_CLEAR: begin
                ram_addr = cnt_q;
                ram_we   = 1'b1;
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR_RD: begin
                state_d = ST_WR_WB;
            end
            ST_WR_WB: begin
                ram_we    = x_ok && y_ok;
                ram_wdata = put_bit(ram_rdata, y_q[2:0], pix_q);
                state_d   = ST_IDLE;
            end
            ST_RD_COL: begin
                if (cnt_q == '0) begin
                    cnt_d = AW'(1);
                end else if (cnt_q == AW'(1)) begin
                    acc_d    = ram_rdata;
                    ram_addr = nxt_addr;
                    ram_en   = nxt_ok;
                    cnt_d    = COL_LAST;
                end else begin
                    dout_d    = (x_ok && y_ok) ? col_word[y_q[2:0] +: 8] : 8'h00;
                    r_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end
            end
            ST_RD_HORZ: begin
                ram_addr = h_addr;
                ram_en   = hx_ok && (cnt_q != HORZ_LAST);
                if (cnt_q != '0) begin
                    acc_d = {acc_q[6:0], h_bit};
                end
                if (cnt_q == HORZ_LAST) begin
                    dout_d    = {acc_q[6:0], h_bit};
                    r_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            pix_q     <= 1'b0;
            acc_q     <= '0;
            dout_q    <= '0;
            r_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pix_q     <= pix_d;
            acc_q     <= acc_d;
            dout_q    <= dout_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign dout    = dout_q;
    assign r_valid = r_valid_q;

    fb_bram #(
        .ADDR_W(AW),
        .DATA_W(8)
    ) u_bram (
        .clk    (clk),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

endmodule

// File: tb/tb_oled_framebuffer.sv
// Bench for oled_framebuffer: directed scenarios plus random writes/reads against a pixel-array model.
module tb_oled_framebuffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       we = 1'b0;
    logic       w_pixel = 1'b0;
    logic       re = 1'b0;
    logic       r_mode = 1'b0;
    logic [7:0] w_xpos = 8'h00;
    logic [7:0] w_ypos = 8'h00;
    logic [7:0] r_xpos = 8'h00;
    logic [7:0] r_ypos = 8'h00;
    logic       ready;
    logic       r_valid;
    logic [7:0] dout;

    int         n_checks = 0;
    int         n_fail = 0;
    bit         fbm [128][64];
    logic [7:0] last_dout = 8'h00;

    always #5 clk = ~clk;

    oled_framebuffer #(
        .DISPLAY_WIDTH (128),
        .DISPLAY_HEIGHT(64),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ready  (ready),
        .clear  (clear),
        .we     (we),
        .w_xpos (w_xpos),
        .w_ypos (w_ypos),
        .w_pixel(w_pixel),
        .re     (re),
        .r_xpos (r_xpos),
        .r_ypos (r_ypos),
        .r_mode (r_mode),
        .dout   (dout),
        .r_valid(r_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit px(input int x, input int y);
        if (x < 0 || x > 127 || y < 0 || y > 63) return 1'b0;
        return fbm[x][y];
    endfunction

    // Column mode: bit i is pixel (x, y+i). Horizontal mode: bit 7-i is pixel (x+i, y).
    function automatic logic [7:0] exp_read(input int x, input int y, input bit mode);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (mode) r[i] = px(x, y + i);
            else      r[7-i] = px(x + i, y);
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int x = 0; x < 128; x++)
            for (int y = 0; y < 64; y++)
                fbm[x][y] = 1'b0;
        last_dout = 8'h00;
    endtask

    task automatic do_reset();
        int k;
        int rv;
        reset = 1'b1;
        clear = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        @(negedge clk);
        check_eq("rst_dout", dout, 8'h00);
        check_eq("rst_rvalid", r_valid, 1'b0);
        check_eq("rst_ready", ready, 1'b0);
        reset = 1'b0;
        k  = 0;
        rv = 0;
        for (int c = 0; c < 1100; c++) begin
            if (ready) break;
            k++;
            if (r_valid) rv++;
            @(negedge clk);
        end
        check_eq("rst_clear_len", k, 1024);
        check_eq("rst_clear_rvalid", rv, 0);
        model_clear();
    endtask

    task automatic wr(input int x, input int y, input bit v);
        int k;
        we      = 1'b1;
        w_xpos  = 8'(x);
        w_ypos  = 8'(y);
        w_pixel = v;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            we = 1'b0;
            if (ready) break;
            k++;
        end
        check_eq($sformatf("wr_busy(%0d,%0d)", x, y), k, 2);
        check_eq("dout_hold", dout, last_dout);
        if (x < 128 && y < 64) fbm[x][y] = v;
    endtask

    task automatic rd(input int x, input int y, input bit mode, output logic [7:0] got);
        int         k;
        int         exp_lat;
        logic [7:0] exp_v;
        exp_v   = exp_read(x, y, mode);
        exp_lat = mode ? (((y % 8) == 0) ? 1 : 3) : 9;
        re      = 1'b1;
        r_xpos  = 8'(x);
        r_ypos  = 8'(y);
        r_mode  = mode;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            re = 1'b0;
            k++;
            if (r_valid) break;
        end
        got = dout;
        check_eq($sformatf("rd_lat(%0d,%0d,m%0d)", x, y, mode), k - 1, exp_lat);
        check_eq($sformatf("rd_data(%0d,%0d,m%0d)", x, y, mode), got, exp_v);
        check_eq("rd_ready", ready, 1'b1);
        last_dout = got;
        @(negedge clk);
        check_eq("rd_pulse", r_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] v;
        int         k;
        int         rv;

        do_reset();
        rd(0, 0, 1'b1, v);
        check_eq("clr_0_0", v, 8'h00);

        wr(5, 0, 1'b1);
        wr(5, 3, 1'b1);
        wr(5, 7, 1'b1);
        rd(5, 0, 1'b1, v);
        check_eq("col_5_0", v, 8'h89);
        rd(5, 0, 1'b1, v);

        wr(10, 6, 1'b1);
        wr(10, 9, 1'b1);
        rd(10, 6, 1'b1, v);
        check_eq("col_10_6", v, 8'h09);
        wr(10, 62, 1'b1);
        wr(10, 63, 1'b1);
        rd(10, 60, 1'b1, v);
        check_eq("col_10_60", v, 8'h0C);

        for (int i = 0; i < 8; i++) wr(120 + i, 20, (i % 2) == 0);
        rd(120, 20, 1'b0, v);
        check_eq("horz_120_20", v, 8'hAA);
        rd(124, 20, 1'b0, v);
        check_eq("horz_124_20", v, 8'hA0);

        // Random traffic concentrated near the right and bottom edges.
        repeat (400) begin
            if ($urandom_range(0, 9) < 7)
                wr($urandom_range(100, 135), $urandom_range(40, 70), $urandom_range(0, 3) != 0);
            else
                rd($urandom_range(100, 135), $urandom_range(40, 70), 1'($urandom_range(0, 1)), v);
        end

        wr(5, 0, 1'b1);
        clear   = 1'b1;
        we      = 1'b1;
        w_xpos  = 8'd5;
        w_ypos  = 8'd1;
        w_pixel = 1'b1;
        re      = 1'b1;
        r_xpos  = 8'd5;
        r_ypos  = 8'd0;
        r_mode  = 1'b1;
        k  = 0;
        rv = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            clear = 1'b0;
            we    = 1'b0;
            re    = 1'b0;
            if (ready) break;
            k++;
            if (r_valid) rv++;
        end
        check_eq("prio_clear_len", k, 1024);
        check_eq("prio_rvalid", rv, 0);
        model_clear();
        rd(5, 0, 1'b1, v);
        check_eq("after_clear", v, 8'h00);

        wr(200, 10, 1'b1);
        wr(5, 70, 1'b1);
        rd(72, 8, 1'b1, v);
        rd(5, 0, 1'b1, v);
        rd(200, 10, 1'b1, v);
        rd(5, 66, 1'b0, v);

        wr(3, 3, 1'b1);
        rd(3, 0, 1'b1, v);
        check_eq("col_3_0", v, 8'h08);
        wr(0, 20, 1'b1);
        re     = 1'b1;
        r_xpos = 8'd0;
        r_ypos = 8'd20;
        r_mode = 1'b0;
        rv = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            re = 1'b0;
            if (r_valid) rv++;
        end
        reset = 1'b1;
        do_reset();
        check_eq("midrd_rvalid", rv, 0);
        rd(3, 0, 1'b1, v);
        rd(0, 20, 1'b0, v);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
